// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
// Sequential radix-2 shift-add multiplier producing P = A*B.
// A single WIDTH+1-bit adder row is reused over WIDTH cycles.
// Signed operation multiplies the operand magnitudes and then negates the
// result when the operand signs differ.
// Start/Busy/Done handshake: a Start accepted on edge t0 updates P on edge
// t(WIDTH+1). Done pulses for the single cycle after that edge. A new Start
// may be issued in the same cycle that Done is high.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Start,
    input  logic                 Signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   p_q;

    logic                 accept;
    logic                 last_bit;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg_in;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   product;

    // Operand conditioning: the magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
    always_comb begin
        a_mag  = A;
        b_mag  = B;
        neg_in = 1'b0;
        if (Signed_mode) begin
            if (A[WIDTH-1]) a_mag = -A;
            if (B[WIDTH-1]) b_mag = -B;
            neg_in = A[WIDTH-1] ^ B[WIDTH-1];
        end
    end

    // One shift-add step. The adder carry becomes the new top bit of the accumulator as it shifts.
    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_next = {sum, acc_q[WIDTH-1:1]};
        product  = neg_q ? -acc_q : acc_q;
    end

    assign accept   = (state_q == IDLE) && Start;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> CALC for WIDTH edges -> FINISH -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start)    state_d = CALC;
            CALC:    if (last_bit) state_d = FINISH;
            FINISH:                state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, step once per CALC cycle, publish the product in FINISH.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            p_q      <= '0;
        end else begin
            done_q <= (state_q == FINISH);
            if (accept) begin
                mcand_q  <= a_mag;
                mplier_q <= b_mag;
                neg_q    <= neg_in;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (state_q == CALC) begin
                acc_q    <= acc_next;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
            end else if (state_q == FINISH) begin
                p_q      <= product;
            end
        end
    end

    assign Busy = (state_q != IDLE);
    assign Done = done_q;
    assign P    = p_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Testbench for seq_shift_add_multiplier.
// Two instances are exercised side by side: WIDTH=4 and WIDTH=8.
// The WIDTH=4 instance gets directed cases followed by an exhaustive sweep.
// The WIDTH=8 instance gets corner cases followed by random pairs.
// Each issued operation pushes its expected product and its expected Done cycle into a queue.
// Monitors pop an entry whenever Done is high.
module tb_seq_shift_add_multiplier;

    localparam int W4 = 4;
    localparam int W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] p;
        int          t;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    logic          r4, start4, sm4, busy4, done4;
    logic [3:0]    a4, b4;
    logic [7:0]    p4;
    logic          r8, start8, sm8, busy8, done8;
    logic [7:0]    a8, b8;
    logic [15:0]   p8;

    seq_shift_add_multiplier #(.WIDTH(W4)) dut4 (
        .Clock(clk), .Resetn(r4), .Start(start4), .Signed_mode(sm4),
        .A(a4), .B(b4), .Busy(busy4), .Done(done4), .P(p4)
    );

    seq_shift_add_multiplier #(.WIDTH(W8)) dut8 (
        .Clock(clk), .Resetn(r8), .Start(start8), .Signed_mode(sm8),
        .A(a8), .B(b8), .Busy(busy8), .Done(done8), .P(p8)
    );

    // Reference product, computed with plain integer arithmetic and truncated to 2*w bits.
    function automatic logic [15:0] ref_mul(int w, logic sm, logic [7:0] a, logic [7:0] b);
        longint av, bv, pr;
        logic [63:0] bits;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        pr   = av * bv;
        bits = 64'(pr) & ((64'd1 << (2*w)) - 64'd1);
        return bits[15:0];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Call at a negedge. Waits for IDLE, drives Start for one cycle, then scrambles the inputs.
    task automatic issue4(logic sm, logic [3:0] a, logic [3:0] b);
        int n = 0;
        while (busy4 !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) fail_now("issue4_timeout");
        sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
        q4.push_back('{ref_mul(W4, sm, {4'b0, a}, {4'b0, b}), cyc + W4 + 2});
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
    endtask

    task automatic issue8(logic sm, logic [7:0] a, logic [7:0] b);
        int n = 0;
        while (busy8 !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) fail_now("issue8_timeout");
        sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back('{ref_mul(W8, sm, a, b), cyc + W8 + 2});
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    endtask

    // Monitor for the WIDTH=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                fail_now("done4_unexpected");
            end else begin
                e = q4.pop_front();
                check("p4", 64'(p4), 64'(e.p));
                check("latency4", 64'(cyc), 64'(e.t));
            end
        end
    end

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                fail_now("done8_unexpected");
            end else begin
                e = q8.pop_front();
                check("p8", 64'(p8), 64'(e.p));
                check("latency8", 64'(cyc), 64'(e.t));
            end
        end
    end

    task automatic seq4();
        // Unsigned max: Busy for 5 cycles, then one Done pulse.
        issue4(1'b0, 4'hF, 4'hF);
        for (int i = 0; i <= 5; i++) begin
            check("t1_busy", 64'(busy4), 64'(i < 5));
            check("t1_done", 64'(done4), 64'(i == 5));
            if (i == 5) check("t1_p", 64'(p4), 64'h00E1);
            if (i < 5) @(negedge clk);
        end
        // Signed and unsigned interpretations of the same bit patterns.
        issue4(1'b1, 4'hD, 4'h5);
        issue4(1'b1, 4'h8, 4'h8);
        issue4(1'b0, 4'h8, 4'h8);
        issue4(1'b0, 4'hD, 4'h5);
        issue4(1'b1, 4'hB, 4'h0);
        // Start while Busy is ignored; Start in the Done cycle is accepted.
        issue4(1'b0, 4'h7, 4'h9);
        @(negedge clk);
        sm4 = 1'b0; a4 = 4'h2; b4 = 4'h2; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        issue4(1'b0, 4'h2, 4'h2);
        // Asynchronous reset during the third CALC cycle aborts without a Done.
        issue4(1'b1, 4'hD, 4'h5);
        @(negedge clk);
        @(negedge clk);
        r4 = 1'b0;
        #1;
        check("t5_busy", 64'(busy4), 64'd0);
        check("t5_done", 64'(done4), 64'd0);
        check("t5_p", 64'(p4), 64'd0);
        void'(q4.pop_back());
        @(negedge clk);
        r4 = 1'b1;
        repeat (8) @(negedge clk);
        issue4(1'b1, 4'h9, 4'h6);
        // Exhaustive sweep in both modes.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    issue4(1'(s), 4'(a), 4'(b));
    endtask

    task automatic seq8();
        issue8(1'b1, 8'h80, 8'h80);
        issue8(1'b0, 8'hFF, 8'hFF);
        issue8(1'b1, 8'hFF, 8'h00);
        issue8(1'b1, 8'h80, 8'h7F);
        issue8(1'b1, 8'hFF, 8'hFF);
        for (int i = 0; i < 2500; i++)
            issue8(1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    initial begin
        int n;
        r4 = 1'b0; r8 = 1'b0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_done4", 64'(done4), 64'd0);
        check("rst_p4", 64'(p4), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_p8", 64'(p8), 64'd0);
        r4 = 1'b1; r8 = 1'b1;
        @(negedge clk);
        fork
            seq4();
            seq8();
        join
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_q4", 64'(q4.size()), 64'd0);
        check("drain_q8", 64'(q8.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
